// File: rtl/m2_sha_pkg.sv
// SHA-256 message schedule shared types and constants.
// K table, IV words, sigma helpers and the scheduler state enum.
package m2_sha_pkg;

  localparam int ROUNDS = 64;
  localparam int WIN    = 16;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/m2_k_rom.sv
// SHA-256 round constant ROM.
// Purely combinational lookup by 6-bit round index.
module m2_k_rom
  import m2_sha_pkg::*;
(
  input  logic [5:0]  round,
  output logic [31:0] k
);

  assign k = K[round];

endmodule

// File: rtl/m2_w_sched.sv
// SHA-256 message schedule: 16-word window, round sequencer.
// Define M2_KW_ADD_EN to fold K[t] into m2_kw_out.
module m2_w_sched
  import m2_sha_pkg::*;
(
  input  logic        clk_h,
  input  logic        rst_h,
  input  logic        clk_h_en,
  input  logic        m2_w_load,
  input  logic [31:0] m2_w_data_in,
  input  logic        m2_start,
  output logic [31:0] m2_w_out,
  output logic [31:0] m2_kw_out,
  output logic [5:0]  m2_round,
  output logic        m2_round_valid,
  output logic        m2_abc_load,
  output logic        m2_busy,
  output logic        m2_done
);

  state_t      state;
  logic [31:0] w [WIN];
  logic [4:0]  load_cnt;
  logic [5:0]  round;
  logic [31:0] w_next;
  logic        shift_in;
  logic        step;
  logic        full;

  assign full     = (load_cnt == 5'(WIN));
  assign shift_in = (state == IDLE) && m2_w_load
                    && clk_h_en && !full;
  assign step     = (state == RUN) && clk_h_en;
  assign w_next   = s1(w[14]) + w[9] + s0(w[1]) + w[0];

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state    <= IDLE;
      load_cnt <= '0;
      round    <= '0;
      for (int i = 0; i < WIN; i++) w[i] <= '0;
    end else begin
      if (shift_in || step) begin
        for (int i = 0; i < WIN - 1; i++) w[i] <= w[i+1];
        w[WIN-1] <= step ? w_next : m2_w_data_in;
      end
      unique case (state)
        IDLE: begin
          if (shift_in) load_cnt <= load_cnt + 5'd1;
          // a start that races the 16th load sees full==0
          if (m2_start && full) state <= INIT;
        end
        INIT: begin
          round <= '0;
          state <= RUN;
        end
        RUN: begin
          if (clk_h_en) begin
            round <= round + 6'd1;
            if (round == 6'(ROUNDS - 1)) state <= DONE;
          end
        end
        DONE: begin
          load_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign m2_w_out       = w[0];
  assign m2_round       = round;
  assign m2_round_valid = step;
  assign m2_abc_load    = (state == INIT);
  assign m2_busy        = (state == INIT) || (state == RUN);
  assign m2_done        = (state == DONE);

`ifdef M2_KW_ADD_EN
  logic [31:0] k;

  m2_k_rom u_k_rom (
    .round (round),
    .k     (k)
  );

  assign m2_kw_out = k + w[0];
`else
  assign m2_kw_out = w[0];
`endif

endmodule

// File: tb/tb_m2_w_sched.sv
// Randomized self-checking bench for m2_w_sched.
// Reference: SHA-256 W expansion computed directly from the block.
module tb_m2_w_sched;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sch_t [64];

  logic        clk_h = 1'b0;
  logic        rst_h = 1'b1;
  logic        clk_h_en = 1'b1;
  logic        m2_w_load = 1'b0;
  logic [31:0] m2_w_data_in = '0;
  logic        m2_start = 1'b0;
  logic [31:0] m2_w_out;
  logic [31:0] m2_kw_out;
  logic [5:0]  m2_round;
  logic        m2_round_valid;
  logic        m2_abc_load;
  logic        m2_busy;
  logic        m2_done;

  int checks = 0;
  int errors = 0;

  m2_w_sched dut (
    .clk_h          (clk_h),
    .rst_h          (rst_h),
    .clk_h_en       (clk_h_en),
    .m2_w_load      (m2_w_load),
    .m2_w_data_in   (m2_w_data_in),
    .m2_start       (m2_start),
    .m2_w_out       (m2_w_out),
    .m2_kw_out      (m2_kw_out),
    .m2_round       (m2_round),
    .m2_round_valid (m2_round_valid),
    .m2_abc_load    (m2_abc_load),
    .m2_busy        (m2_busy),
    .m2_done        (m2_done)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sch_t expand(input blk_t m);
    sch_t r;
    logic [31:0] a, b;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) r[t] = m[t];
      else begin
        a = rotr(r[t-15], 7) ^ rotr(r[t-15], 18) ^ (r[t-15] >> 3);
        b = rotr(r[t-2], 17) ^ rotr(r[t-2], 19) ^ (r[t-2] >> 10);
        r[t] = b + r[t-7] + a + r[t-16];
      end
    end
    return r;
  endfunction

  task automatic load_block(input blk_t m, input int n,
                            input int extra, input bit gated);
    int i = 0;
    while (i < n) begin
      m2_w_load = 1'b1;
      if (gated && $urandom_range(0, 3) == 0) begin
        clk_h_en = 1'b0;
        m2_w_data_in = $urandom;
      end else begin
        clk_h_en = 1'b1;
        m2_w_data_in = m[i];
        i++;
      end
      @(negedge clk_h);
    end
    clk_h_en = 1'b1;
    for (int j = 0; j < extra; j++) begin
      m2_w_data_in = $urandom;
      @(negedge clk_h);
    end
    m2_w_load = 1'b0;
  endtask

  task automatic run_block(input blk_t m, input bit toggle,
                           input bit is_abc, input int abort_at);
    sch_t ws;
    int cnt = 0;
    int cyc = 0;
    ws = expand(m);
    clk_h_en = 1'b1;
    m2_start = 1'b1;
    @(negedge clk_h);
    m2_start = 1'b0;
    chk("abc_load", 32'(m2_abc_load), 32'd1);
    chk("init_busy", 32'(m2_busy), 32'd1);
    chk("init_round", 32'(m2_round), 32'd0);
    chk("init_valid", 32'(m2_round_valid), 32'd0);
    @(negedge clk_h);
    while (cnt < 64 && cyc < 400) begin
      clk_h_en = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      m2_w_load = 1'($urandom_range(0, 1));
      m2_w_data_in = $urandom;
      #1;
      chk("valid", 32'(m2_round_valid), 32'(clk_h_en));
      chk("round", 32'(m2_round), 32'(cnt));
      chk("w_out", m2_w_out, ws[cnt]);
      chk("abc_load_run", 32'(m2_abc_load), 32'd0);
`ifdef M2_KW_ADD_EN
      if (is_abc && cnt == 0) chk("abc_kw0", m2_kw_out, 32'ha3ec9318);
`else
      chk("kw_eq_w", m2_kw_out, ws[cnt]);
`endif
      if (is_abc && cnt == 0) chk("abc_w0", m2_w_out, 32'h61626380);
      if (is_abc && cnt == 16) chk("abc_w16", m2_w_out, 32'h61626380);
      if (is_abc && cnt == 17) chk("abc_w17", m2_w_out, 32'h000f0000);
      if (cnt == abort_at) begin
        rst_h = 1'b1;
        m2_w_load = 1'b0;
        @(negedge clk_h);
        rst_h = 1'b0;
        clk_h_en = 1'b1;
        #1;
        chk("rst_busy", 32'(m2_busy), 32'd0);
        chk("rst_w_out", m2_w_out, 32'd0);
        chk("rst_round", 32'(m2_round), 32'd0);
        chk("rst_valid", 32'(m2_round_valid), 32'd0);
        chk("rst_done", 32'(m2_done), 32'd0);
        @(negedge clk_h);
        return;
      end
      if (clk_h_en) cnt++;
      cyc++;
      @(negedge clk_h);
    end
    m2_w_load = 1'b0;
    clk_h_en = 1'b1;
    if (cnt != 64) chk("round_budget", 32'(cnt), 32'd64);
    chk("done", 32'(m2_done), 32'd1);
    chk("done_busy", 32'(m2_busy), 32'd0);
    chk("done_valid", 32'(m2_round_valid), 32'd0);
    @(negedge clk_h);
    chk("done_pulse", 32'(m2_done), 32'd0);
    chk("idle_busy", 32'(m2_busy), 32'd0);
    // load count must be cleared, so a bare start is ignored
    m2_start = 1'b1;
    @(negedge clk_h);
    m2_start = 1'b0;
    chk("post_start_busy", 32'(m2_busy), 32'd0);
    chk("post_start_abc", 32'(m2_abc_load), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    blk_t blk;
    repeat (2) @(negedge clk_h);
    rst_h = 1'b0;
    chk("rst0_w_out", m2_w_out, 32'd0);
    chk("rst0_round", 32'(m2_round), 32'd0);
    chk("rst0_busy", 32'(m2_busy), 32'd0);
    chk("rst0_valid", 32'(m2_round_valid), 32'd0);
    chk("rst0_abc", 32'(m2_abc_load), 32'd0);
    chk("rst0_done", 32'(m2_done), 32'd0);

    blk = '{default: 32'd0};
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    load_block(blk, 16, 0, 1'b0);
    run_block(blk, 1'b0, 1'b1, -1);
    load_block(blk, 16, 0, 1'b0);
    run_block(blk, 1'b1, 1'b1, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      load_block(blk, 16, r + 1, 1'b1);
      run_block(blk, r[0], 1'b0, -1);
    end

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(blk, 15, 0, 1'b0);
    m2_start = 1'b1;
    @(negedge clk_h);
    m2_start = 1'b0;
    chk("s15_busy", 32'(m2_busy), 32'd0);
    chk("s15_abc", 32'(m2_abc_load), 32'd0);
    m2_w_load = 1'b1;
    m2_w_data_in = blk[15];
    m2_start = 1'b1;
    @(negedge clk_h);
    m2_w_load = 1'b0;
    m2_start = 1'b0;
    chk("race_busy", 32'(m2_busy), 32'd0);
    chk("race_abc", 32'(m2_abc_load), 32'd0);
    run_block(blk, 1'b0, 1'b0, -1);

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(blk, 16, 0, 1'b0);
    run_block(blk, 1'b0, 1'b0, 30);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(blk, 16, 0, 1'b0);
    run_block(blk, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2_w_sched.md
M2_W_SCHED -- requirements
Module: m2_w_sched

Interface
REQ-001 The block SHALL have these ports:
- clk_h, in, 1: sole clock; all logic on the rising edge.
- rst_h, in, 1: synchronous, active-high reset.
- clk_h_en, in, 1: advance enable; gates word loads and round advance.
- m2_w_load, in, 1: strobe to shift m2_w_data_in into the message window.
- m2_w_data_in, in, 32: message word; W0 is sent first, W15 last.
- m2_start, in, 1: request to run 64 rounds on the loaded block.
- m2_w_out, out, 32: W_t for the current round (registered window head).
- m2_kw_out, out, 32: K_t + W_t mod 2^32 (see REQ-016).
- m2_round, out, 6: current round index t.
- m2_round_valid, out, 1: high for one round step; the downstream abc register uses it as its clk_h_en.
- m2_abc_load, out, 1: one-cycle pulse that loads the IV into the downstream abc register.
- m2_busy, out, 1: high in INIT and RUN.
- m2_done, out, 1: one-cycle pulse after round 63.

Function
REQ-002 The window SHALL hold 16 x 32-bit words w[0..15], with w[0] as the oldest word.
REQ-003 In IDLE, m2_w_load & clk_h_en SHALL shift the window: w[i] <= w[i+1], w[15] <= m2_w_data_in, load_cnt += 1.
- load_cnt saturates at 16.
- Loads after 16 are ignored.
- Loads outside IDLE are ignored.
REQ-004 The state machine SHALL have four states: IDLE, INIT, RUN and DONE.
REQ-005 The transition IDLE->INIT SHALL occur only on m2_start with load_cnt==16; otherwise m2_start is ignored.
REQ-006 INIT SHALL last exactly one cycle, with m2_abc_load=1 and m2_round=0; INIT->RUN is unconditional.
REQ-007 In RUN, each cycle with clk_h_en=1 SHALL perform one round step:
- m2_round_valid=1;
- w[i] <= w[i+1];
- w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0] mod 2^32;
- m2_round += 1.
REQ-008 The sigma functions SHALL be:
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3;
- s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-009 In RUN with clk_h_en=0, state, window and m2_round SHALL hold, and m2_round_valid SHALL be 0.
REQ-010 m2_w_out SHALL equal w[0] at all times, so that m2_w_out = W_t during RUN.
REQ-011 The round step with m2_round==63 SHALL move the state to DONE; m2_round wraps to 0.
REQ-012 DONE SHALL last one cycle with m2_done=1, then go to IDLE with load_cnt cleared.
REQ-013 Latency: m2_start accepted at edge N -> m2_abc_load high in cycle N+1 -> first m2_round_valid in cycle N+2 (if clk_h_en=1).
REQ-014 When m2_w_load and m2_start are both high in IDLE with load_cnt==15, the load SHALL be taken and the start ignored.

Reset
REQ-015 With rst_h=1 at a clock edge, from any state (including mid-RUN), the block SHALL return to the following within that edge:
- state = IDLE;
- load_cnt = 0;
- window = 0;
- m2_round = 0;
- m2_round_valid, m2_abc_load, m2_busy and m2_done = 0.

Configuration
REQ-016 Macro M2_KW_ADD_EN SHALL select the m2_kw_out behaviour:
- Defined: a 64-entry K ROM indexed by m2_round is built in, and m2_kw_out = K[m2_round] + w[0] mod 2^32.
- Undefined: the ROM is omitted and m2_kw_out = w[0].

Structure
REQ-017 Package m2_sha_pkg SHALL hold:
- the K[0..63] constant table;
- the SHA-256 IV constants;
- s0/s1 functions;
- the state enum;
- ROUNDS=64 and WIN=16 constants.
REQ-018 The K ROM SHALL be the single sub-module m2_k_rom, which is combinational, indexed by a 6-bit round, and instantiated only under M2_KW_ADD_EN.

Verification
REQ-019 "abc" block (W0=0x61626380, W15=0x00000018, all other words 0), then start:
- round 0: m2_w_out=0x61626380, and m2_kw_out=0xA3EC9318 with the macro defined;
- round 16: m2_w_out=0x61626380;
- round 17: m2_w_out=0x000F0000.
REQ-020 Latency check: start -> m2_abc_load exactly one cycle later; exactly 64 m2_round_valid pulses; m2_done one cycle after round 63; m2_busy low afterwards.
REQ-021 clk_h_en toggled 1/0 during RUN: m2_round_valid count = 64, and W values are identical to the continuous run.
REQ-022 Start with only 15 words loaded: the start is ignored and the state stays IDLE; the 16th load followed by start then runs.
REQ-023 rst_h asserted at round 30: the next cycle shows IDLE, m2_w_out=0 and m2_round=0; a reload plus start gives a correct run.
REQ-024 Macro undefined: m2_kw_out == m2_w_out on every round of the "abc" run.
